// File: rtl/iobus_pkg.sv
// Shared definitions for the IO bus command master: FSM states,
// default parameter values and the per-lane read-data mask.
package iobus_pkg;

    localparam int DEF_DATA_W         = 32;
    localparam int DEF_ADDR_W         = 32;
    localparam int DEF_CMD_DEPTH      = 4;
    localparam int DEF_TIMEOUT_CYCLES = 255;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } iobus_state_e;

    // One byte lane of read data, zeroed when its byte enable is low.
    function automatic logic [7:0] lane_mask(input logic [7:0] lane, input logic en);
        return en ? lane : 8'h00;
    endfunction

endpackage

// File: rtl/iobus_sync_fifo.sv
// Single-clock show-ahead FIFO. Pointers carry one extra wrap bit so
// full and empty are distinguished without a separate counter.
module iobus_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout  = mem[rd_ptr[AW-1:0]];

    // Pointer advance; pushes into a full FIFO and pops from an empty one are ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop && !empty)
                rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage write; contents need no reset since the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/iobus_cmd_master.sv
// Queues read/write commands and plays them one at a time onto a
// MicroBlaze-style IO bus, returning one response per command in order,
// with an abort after a bounded number of wait cycles.
module iobus_cmd_master import iobus_pkg::*; #(
    parameter int DATA_W         = DEF_DATA_W,
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int CMD_DEPTH      = DEF_CMD_DEPTH,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic [DATA_W-1:0]     cmd_wdata,
    input  logic [DATA_W/8-1:0]   cmd_byte_en,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_write,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_timeout,
    output logic                  busy,
    output logic                  io_addr_strobe,
    output logic                  io_read_strobe,
    output logic                  io_write_strobe,
    output logic [ADDR_W-1:0]     io_addr,
    output logic [DATA_W/8-1:0]   io_byte_en,
    output logic [DATA_W-1:0]     io_write_data,
    input  logic [DATA_W-1:0]     io_read_data,
    input  logic                  io_ready
);

    localparam int BE_W  = DATA_W / 8;
    localparam int CMD_W = 1 + ADDR_W + BE_W + DATA_W;
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    iobus_state_e      state;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_pop;
    logic [CMD_W-1:0]  fifo_din;
    logic [CMD_W-1:0]  fifo_dout;
    logic              head_write;
    logic [ADDR_W-1:0] head_addr;
    logic [BE_W-1:0]   head_be;
    logic [DATA_W-1:0] head_wdata;
    logic              cur_write;
    logic [BE_W-1:0]   cur_be;
    logic [CNT_W-1:0]  wait_cnt;
    logic [DATA_W-1:0] masked_rdata;

    assign cmd_ready = !fifo_full;
    assign fifo_din  = {cmd_write, cmd_addr, cmd_byte_en, cmd_wdata};
    assign {head_write, head_addr, head_be, head_wdata} = fifo_dout;
    assign fifo_pop  = (state == ST_IDLE) && !fifo_empty;
    assign busy      = !fifo_empty || (state != ST_IDLE);

    iobus_sync_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (CMD_DEPTH)
    ) u_cmd_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cmd_valid),
        .din   (fifo_din),
        .full  (fifo_full),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .empty (fifo_empty)
    );

    // Read data with disabled byte lanes forced to zero.
    always_comb begin
        masked_rdata = '0;
        for (int unsigned i = 0; i < BE_W; i++)
            masked_rdata[i*8 +: 8] = lane_mask(io_read_data[i*8 +: 8], cur_be[i]);
    end

    // Transaction sequencer: pop, one-cycle strobe, bounded wait, hold response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= ST_IDLE;
            io_addr_strobe  <= 1'b0;
            io_read_strobe  <= 1'b0;
            io_write_strobe <= 1'b0;
            io_addr         <= '0;
            io_byte_en      <= '0;
            io_write_data   <= '0;
            rsp_valid       <= 1'b0;
            rsp_write       <= 1'b0;
            rsp_rdata       <= '0;
            rsp_timeout     <= 1'b0;
            cur_write       <= 1'b0;
            cur_be          <= '0;
            wait_cnt        <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        state           <= ST_ISSUE;
                        io_addr_strobe  <= 1'b1;
                        io_read_strobe  <= !head_write;
                        io_write_strobe <= head_write;
                        io_addr         <= head_addr;
                        io_byte_en      <= head_be;
                        io_write_data   <= head_write ? head_wdata : '0;
                        cur_write       <= head_write;
                        cur_be          <= head_be;
                    end
                end
                ST_ISSUE: begin
                    state           <= ST_WAIT;
                    io_addr_strobe  <= 1'b0;
                    io_read_strobe  <= 1'b0;
                    io_write_strobe <= 1'b0;
                    io_addr         <= '0;
                    io_byte_en      <= '0;
                    io_write_data   <= '0;
                    wait_cnt        <= '0;
                end
                ST_WAIT: begin
                    // io_ready is tested first so a last-cycle acknowledge wins over the abort.
                    if (io_ready) begin
                        state       <= ST_RESP;
                        rsp_valid   <= 1'b1;
                        rsp_write   <= cur_write;
                        rsp_rdata   <= cur_write ? '0 : masked_rdata;
                        rsp_timeout <= 1'b0;
                    end else if (wait_cnt == CNT_LAST) begin
                        state       <= ST_RESP;
                        rsp_valid   <= 1'b1;
                        rsp_write   <= cur_write;
                        rsp_rdata   <= '0;
                        rsp_timeout <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state       <= ST_IDLE;
                        rsp_valid   <= 1'b0;
                        rsp_write   <= 1'b0;
                        rsp_rdata   <= '0;
                        rsp_timeout <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_iobus_cmd_master.sv
// Bench for iobus_cmd_master: directed single-transaction table, multi-cycle
// sequences for back-pressure and reset, then randomized traffic against a
// timestamp-based reference model.
module tb_iobus_cmd_master;

    localparam int DW      = 32;
    localparam int AW      = 32;
    localparam int BW      = 4;
    localparam int DEPTH   = 4;
    localparam int TMO     = 8;
    localparam int RND_CYC = 3000;
    localparam logic [31:0] KEY = 32'hC0DE0000;

    logic          clk;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [BW-1:0] cmd_byte_en;
    logic          rsp_valid;
    logic          rsp_ready;
    logic          rsp_write;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_timeout;
    logic          busy;
    logic          io_addr_strobe;
    logic          io_read_strobe;
    logic          io_write_strobe;
    logic [AW-1:0] io_addr;
    logic [BW-1:0] io_byte_en;
    logic [DW-1:0] io_write_data;
    logic [DW-1:0] io_read_data;
    logic          io_ready;

    iobus_cmd_master #(
        .DATA_W         (DW),
        .ADDR_W         (AW),
        .CMD_DEPTH      (DEPTH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_write       (cmd_write),
        .cmd_addr        (cmd_addr),
        .cmd_wdata       (cmd_wdata),
        .cmd_byte_en     (cmd_byte_en),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_write       (rsp_write),
        .rsp_rdata       (rsp_rdata),
        .rsp_timeout     (rsp_timeout),
        .busy            (busy),
        .io_addr_strobe  (io_addr_strobe),
        .io_read_strobe  (io_read_strobe),
        .io_write_strobe (io_write_strobe),
        .io_addr         (io_addr),
        .io_byte_en      (io_byte_en),
        .io_write_data   (io_write_data),
        .io_read_data    (io_read_data),
        .io_ready        (io_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total;
    int n_pass;

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [31:0] rd;
        int          j;          // WAIT cycle on which the slave acks; 0 = never
        bit          issue_rdy;  // spurious io_ready during the strobe cycle
        logic [31:0] exp_rd;
        bit          exp_to;
    } vec_t;

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [3:0]  be;
        logic [31:0] wd;
        int          pe;         // edge at which the command was pushed
    } cmd_t;

    vec_t tbl [8];

    // reference-model state for the random phase
    cmd_t        q[$];
    cmd_t        cur;
    cmd_t        nc;
    int          cyc;
    int          free_edge;
    int          issue_edge;
    int          j_ack;
    int          eff;
    bit          inflight;
    bit          holding;
    bit          pushed;
    bit          hs;
    bit          strobe_exp;
    logic [31:0] slv_data;
    logic        exp_w;
    logic        exp_to;
    logic [31:0] exp_rd;
    logic [70:0] exp_io;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [31:0] lane_and(input logic [31:0] d, input logic [3:0] be);
        logic [31:0] m;
        m = 32'h0;
        for (int i = 0; i < 4; i++)
            if (be[i]) m = m | (32'hFF << (8 * i));
        return d & m;
    endfunction

    function automatic logic [70:0] io_now();
        return {io_addr_strobe, io_read_strobe, io_write_strobe, io_addr, io_byte_en, io_write_data};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input logic w, input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd);
        cmd_valid   = 1'b1;
        cmd_write   = w;
        cmd_addr    = a;
        cmd_byte_en = be;
        cmd_wdata   = wd;
    endtask

    task automatic run_txn(input vec_t v, input string tag);
        logic [70:0] ev;
        int e;
        e = (v.j == 0) ? TMO : v.j;
        set_cmd(v.w, v.a, v.be, v.wd);
        tick();
        cmd_valid = 1'b0;
        chk({tag, ":busy_after_push"}, busy, 1'b1);
        chk({tag, ":no_strobe_yet"}, io_addr_strobe, 1'b0);
        tick();
        ev = {1'b1, !v.w, v.w, v.a, v.be, (v.w ? v.wd : 32'h0)};
        chk({tag, ":issue"}, io_now(), ev);
        if (v.issue_rdy) begin
            io_ready     = 1'b1;
            io_read_data = v.rd;
        end
        tick();
        io_ready = 1'b0;
        chk({tag, ":strobe_one_cycle"}, io_now(), 71'h0);
        for (int k = 1; k <= e; k++) begin
            if (k == v.j) begin
                io_ready     = 1'b1;
                io_read_data = v.rd;
            end
            tick();
            io_ready     = 1'b0;
            io_read_data = $urandom;
            chk($sformatf("%s:rsp_valid_w%0d", tag, k), rsp_valid, (k == e));
        end
        chk({tag, ":rsp"}, {rsp_write, rsp_timeout, rsp_rdata}, {v.w, v.exp_to, v.exp_rd});
        tick();
        chk({tag, ":rsp_held"}, {rsp_valid, rsp_write, rsp_timeout, rsp_rdata}, {1'b1, v.w, v.exp_to, v.exp_rd});
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk({tag, ":rsp_done"}, {rsp_valid, busy}, 2'b00);
    endtask

    initial begin
        int          got;
        bit          pend;
        bit          acc;
        int          bad;
        logic [31:0] lat_addr;
        logic [31:0] ord [6];

        n_total = 0;
        n_pass  = 0;
        rst          = 1'b1;
        cmd_valid    = 1'b0;
        cmd_write    = 1'b0;
        cmd_addr     = '0;
        cmd_wdata    = '0;
        cmd_byte_en  = '0;
        rsp_ready    = 1'b0;
        io_ready     = 1'b0;
        io_read_data = '0;

        //            w     addr         be    wdata         rdata         j  issue  exp_rd        exp_to
        tbl[0] = '{1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 32'hAAAAAAAA, 2, 1'b0, 32'h00000000, 1'b0};
        tbl[1] = '{1'b0, 32'h20, 4'h5, 32'h0,        32'h11223344, 1, 1'b0, 32'h00220044, 1'b0};
        tbl[2] = '{1'b0, 32'h30, 4'hF, 32'h0,        32'hCAFEF00D, 8, 1'b0, 32'hCAFEF00D, 1'b0};
        tbl[3] = '{1'b0, 32'h40, 4'hA, 32'h0,        32'h12345678, 0, 1'b0, 32'h00000000, 1'b1};
        tbl[4] = '{1'b0, 32'h44, 4'h0, 32'h0,        32'hFFFFFFFF, 3, 1'b0, 32'h00000000, 1'b0};
        tbl[5] = '{1'b0, 32'h48, 4'h8, 32'h0,        32'hA1B2C3D4, 0, 1'b1, 32'h00000000, 1'b1};
        tbl[6] = '{1'b1, 32'h50, 4'h3, 32'h01020304, 32'h55667788, 0, 1'b0, 32'h00000000, 1'b1};
        tbl[7] = '{1'b0, 32'h54, 4'hC, 32'h0,        32'h89ABCDEF, 5, 1'b0, 32'h89AB0000, 1'b0};

        // reset state
        tick();
        tick();
        chk("reset_io", io_now(), 71'h0);
        chk("reset_rsp", {rsp_valid, rsp_write, rsp_timeout, rsp_rdata}, 35'h0);
        chk("reset_busy_ready", {busy, cmd_ready}, 2'b01);
        rst = 1'b0;
        tick();
        chk("idle_after_release", {busy, cmd_ready, io_addr_strobe}, 3'b010);

        // directed single transactions
        for (int i = 0; i < 8; i++)
            run_txn(tbl[i], $sformatf("vec%0d", i));

        // back-pressure: hold one response, fill the FIFO, then drain in order
        ord[0] = 32'h100;
        for (int i = 1; i < 6; i++)
            ord[i] = 32'h100 + 32'(4 * i);
        set_cmd(1'b0, ord[0], 4'hF, 32'h0);
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        io_ready     = 1'b1;
        io_read_data = ord[0] ^ KEY;
        tick();
        io_ready = 1'b0;
        chk("bp_first_rsp", {rsp_valid, rsp_rdata}, {1'b1, ord[0] ^ KEY});
        for (int i = 1; i <= 4; i++) begin
            set_cmd(1'b0, ord[i], 4'hF, 32'h0);
            chk($sformatf("bp_ready_before_push%0d", i), cmd_ready, 1'b1);
            tick();
        end
        set_cmd(1'b0, ord[5], 4'hF, 32'h0);
        chk("bp_full_after_4", cmd_ready, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("bp_stalled%0d", i), {cmd_ready, rsp_valid, rsp_rdata}, {1'b0, 1'b1, ord[0] ^ KEY});
        end
        got       = 1;
        pend      = 1'b0;
        lat_addr  = '0;
        rsp_ready = 1'b1;
        for (int c = 0; c < 120 && got < 6; c++) begin
            acc = cmd_valid && cmd_ready;
            tick();
            if (acc) cmd_valid = 1'b0;
            io_ready = 1'b0;
            if (pend) begin
                io_ready     = 1'b1;
                io_read_data = lat_addr ^ KEY;
                pend         = 1'b0;
            end
            if (io_addr_strobe) begin
                pend     = 1'b1;
                lat_addr = io_addr;
            end
            if (rsp_valid) begin
                chk($sformatf("bp_order%0d", got), rsp_rdata, ord[got] ^ KEY);
                got++;
            end
        end
        chk("bp_all_responses", got, 6);
        rsp_ready = 1'b0;
        cmd_valid = 1'b0;
        io_ready  = 1'b0;
        tick();
        tick();

        // reset during WAIT with two commands queued
        set_cmd(1'b0, 32'h200, 4'hF, 32'h0);
        tick();
        set_cmd(1'b0, 32'h204, 4'hF, 32'h0);
        tick();
        set_cmd(1'b1, 32'h208, 4'hF, 32'h12345678);
        tick();
        cmd_valid = 1'b0;
        tick();
        chk("rst_wait_busy_before", busy, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_wait_async", {io_now(), rsp_valid, busy, cmd_ready}, {71'h0, 1'b0, 1'b0, 1'b1});
        @(posedge clk);
        #1;
        rst = 1'b0;
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            io_ready     = $urandom_range(0, 1);
            io_read_data = $urandom;
            tick();
            if (rsp_valid || io_addr_strobe || busy || !cmd_ready) bad++;
        end
        io_ready = 1'b0;
        chk("rst_wait_dropped", bad, 0);

        // reset during the strobe cycle clears the bus outputs at once
        set_cmd(1'b1, 32'h300, 4'h6, 32'hFEEDFACE);
        tick();
        cmd_valid = 1'b0;
        tick();
        chk("rst_issue_before", {io_addr_strobe, io_write_strobe}, 2'b11);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_issue_async", io_now(), 71'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        chk("rst_issue_idle", {busy, rsp_valid}, 2'b00);

        // randomized traffic against the reference model
        q.delete();
        cyc        = 0;
        free_edge  = 0;
        issue_edge = 0;
        inflight   = 1'b0;
        holding    = 1'b0;
        j_ack      = 0;
        eff        = 0;
        cmd_valid  = 1'b0;
        rsp_ready  = 1'b0;
        for (int it = 0; it < RND_CYC + 400; it++) begin
            if (it >= RND_CYC && q.size() == 0 && !inflight && !holding) break;
            pushed = cmd_valid && (q.size() < DEPTH);
            hs     = holding && rsp_ready;
            tick();
            cyc++;
            if (pushed) begin
                nc.pe = cyc;
                q.push_back(nc);
            end
            if (hs) begin
                holding   = 1'b0;
                free_edge = cyc;
            end
            strobe_exp = 1'b0;
            if (!inflight && !holding && q.size() != 0 && cyc > q[0].pe && cyc > free_edge) begin
                cur        = q.pop_front();
                inflight   = 1'b1;
                issue_edge = cyc;
                strobe_exp = 1'b1;
                j_ack      = ($urandom_range(0, 3) != 0) ? $urandom_range(1, 3) : $urandom_range(1, TMO + 3);
                eff        = (j_ack > TMO) ? TMO : j_ack;
                slv_data   = $urandom;
            end else if (inflight && cyc == issue_edge + 1 + eff) begin
                inflight = 1'b0;
                holding  = 1'b1;
                exp_w    = cur.w;
                exp_to   = (j_ack > TMO);
                exp_rd   = (cur.w || exp_to) ? 32'h0 : lane_and(slv_data, cur.be);
            end
            exp_io = strobe_exp ? {1'b1, !cur.w, cur.w, cur.a, cur.be, (cur.w ? cur.wd : 32'h0)} : 71'h0;
            chk("rnd_io", io_now(), exp_io);
            chk("rnd_rsp_valid", rsp_valid, holding);
            if (holding)
                chk("rnd_rsp", {rsp_write, rsp_timeout, rsp_rdata}, {exp_w, exp_to, exp_rd});
            chk("rnd_cmd_ready", cmd_ready, (q.size() < DEPTH));
            chk("rnd_busy", busy, (q.size() != 0 || inflight || holding));

            if (it >= RND_CYC) begin
                cmd_valid = 1'b0;
                rsp_ready = 1'b1;
            end else begin
                nc.w  = 1'($urandom_range(0, 1));
                nc.a  = $urandom;
                nc.be = 4'($urandom);
                nc.wd = $urandom;
                nc.pe = 0;
                cmd_valid   = ($urandom_range(0, 99) < 45);
                cmd_write   = nc.w;
                cmd_addr    = nc.a;
                cmd_byte_en = nc.be;
                cmd_wdata   = nc.wd;
                rsp_ready   = 1'($urandom_range(0, 1));
            end
            io_ready     = 1'b0;
            io_read_data = $urandom;
            if (inflight && j_ack <= TMO && cyc == issue_edge + j_ack) begin
                io_ready     = 1'b1;
                io_read_data = slv_data;
            end else if ((inflight && cyc == issue_edge) || holding) begin
                io_ready = 1'($urandom_range(0, 1));
            end
        end
        chk("rnd_drained", {busy, rsp_valid}, 2'b00);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/iobus_cmd_master.md
IOBUS_CMD_MASTER -- requirements
Module: iobus_cmd_master

Interface
REQ-001 Parameter DATA_W, default 32, IO data width; SHALL be a multiple of 8; BE_W = DATA_W/8.
REQ-002 Parameter ADDR_W, default 32, IO address width.
REQ-003 Parameter CMD_DEPTH, default 4, command FIFO entries; SHALL be a power of 2 and at least 2.
REQ-004 Parameter TIMEOUT_CYCLES, default 255, maximum WAIT cycles before abort; SHALL be at least 1.
REQ-005 clk  in  1  single clock; all logic is rising-edge.
REQ-006 rst  in  1  reset; asynchronous, active-high.
REQ-007 cmd_valid  in  1  command offered.
REQ-008 cmd_ready  out  1  command FIFO not full.
REQ-009 cmd_write  in  1  1 = write, 0 = read.
REQ-010 cmd_addr  in  ADDR_W  target address.
REQ-011 cmd_wdata  in  DATA_W  write data.
REQ-012 cmd_byte_en  in  BE_W  lane enables.
REQ-013 rsp_valid  out  1  response held.
REQ-014 rsp_ready  in  1  response consumed.
REQ-015 rsp_write  out  1  echo of cmd_write.
REQ-016 rsp_rdata  out  DATA_W  masked read data; 0 for writes and timeouts.
REQ-017 rsp_timeout  out  1  transaction aborted by timeout.
REQ-018 busy  out  1  FIFO non-empty or FSM not IDLE.
REQ-019 io_addr_strobe, io_read_strobe, io_write_strobe  out  1 each  MicroBlaze IO bus strobes.
REQ-020 io_addr  out  ADDR_W; io_byte_en  out  BE_W; io_write_data  out  DATA_W.
REQ-021 io_read_data  in  DATA_W; io_ready  in  1  slave acknowledge.

Function
REQ-022 Command push SHALL occur on a rising edge with cmd_valid && cmd_ready; cmd_ready SHALL equal !full and SHALL NOT depend on a same-cycle pop.
REQ-023 FSM states SHALL be IDLE, ISSUE, WAIT and RESP.
REQ-024 IDLE with FIFO non-empty SHALL pop the head and enter ISSUE on the next edge; an empty FIFO keeps the FSM in IDLE.
REQ-025 ISSUE SHALL last exactly 1 cycle, with all outputs registered:
- io_addr_strobe = 1.
- io_read_strobe = !write; io_write_strobe = write.
- io_addr and io_byte_en from the command.
- io_write_data = wdata for a write, 0 for a read.
REQ-026 Outside ISSUE, all io_* outputs SHALL be 0.
REQ-027 io_ready SHALL be sampled only in WAIT; io_ready in any other state SHALL be ignored.
REQ-028 WAIT with io_ready = 1 SHALL capture the response into RESP on that edge:
- rsp_rdata = io_read_data with lanes of byte_en = 0 forced to 0; 0 for a write.
- rsp_timeout = 0.
REQ-029 The WAIT counter SHALL clear on WAIT entry and increment each WAIT cycle.
REQ-030 With io_ready low and counter == TIMEOUT_CYCLES-1, the FSM SHALL enter RESP with rsp_timeout = 1 and rsp_rdata = 0.
REQ-031 io_ready and the timeout occurring in the same cycle SHALL resolve as success.
REQ-032 RESP SHALL assert rsp_valid with stable data until rsp_ready is seen; it SHALL then return to IDLE on that edge.
REQ-033 Latency: a command pushed at edge t0 into an idle, empty block SHALL give strobes in cycle t1..t2; io_ready at edge t3 SHALL give rsp_valid from t3.
REQ-034 Commands SHALL complete strictly in order, with at most one outstanding on the IO bus.
REQ-035 FIFO pointers SHALL be log2(CMD_DEPTH)+1 bits and wrap modulo 2*CMD_DEPTH; full and empty derive from the pointer MSB and compare.

Reset
REQ-036 rst SHALL asynchronously force:
- FSM to IDLE and the FIFO to empty.
- All io_* outputs, rsp_* outputs and busy to 0; cmd_ready to 1.
REQ-037 rst asserted mid-transaction SHALL drop the pending command and all queued commands, with no response generated.
REQ-038 Release SHALL be synchronous to the first clk edge after deassertion.

Structure
REQ-039 Package iobus_pkg SHALL hold the FSM state encoding, default parameter values and the byte-lane mask function.
REQ-040 The command FIFO SHALL be a sub-module iobus_sync_fifo, parametrised by width and depth, with the same clk/rst.

Verification
REQ-041 Write 0x10 = 0xDEADBEEF, be = 4'b1111, slave io_ready 2 cycles after strobe -> one 1-cycle io_write_strobe; rsp_valid with rsp_write = 1, rsp_timeout = 0.
REQ-042 Read 0x20, be = 4'b0101, io_read_data = 0x11223344 -> io_read_strobe 1 cycle; rsp_rdata = 0x00220044.
REQ-043 Push 5 commands with CMD_DEPTH = 4 and responses stalled -> cmd_ready low after the 4th; responses arrive in push order after release.
REQ-044 TIMEOUT_CYCLES = 8, slave never ready -> rsp_timeout = 1 and rsp_rdata = 0 exactly 8 cycles after WAIT entry.
REQ-045 Assert rst during WAIT with 2 commands queued -> outputs 0 immediately; no rsp_valid afterwards; busy = 0.
REQ-046 io_ready pulsed during ISSUE only -> ignored; the transaction times out.
